// File: rtl/block_sequencer.sv
// block_sequencer
//   Per-sample instruction sequencer for one processing block. The block's
//   program lives in a local synchronous RAM loaded over the cfg write port.
//   Each accepted sample_tick issues instructions 0..len-1, in order, to the
//   decoder over a valid/ready handshake (up to one instruction per cycle).
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cfg_we/addr/data    program RAM write port (ignored while busy)
//   cfg_len             program length 0..n_instrs, latched at tick accept
//   sample_tick         one-cycle pulse that starts a program pass
//   instr_out/valid     instruction to the decoder, pc_out is its index
//   instr_ready         decoder accepts instr_out this cycle
//   busy                a pass is in progress
//   done                one-cycle pulse at the end of a pass
//   overrun             sticky: a tick arrived while not idle and was dropped
//   cfg_reject          one-cycle pulse: a cfg write was dropped while busy
//
// State table
//   state | meaning
//   IDLE  | waiting for sample_tick, RAM writable
//   FETCH | read of pc 0 in flight, nothing valid yet
//   ISSUE | instruction pc presented, advances on handshake
//   DONE  | done pulse, back to IDLE next cycle

`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

module block_sequencer #(
  parameter int instr_width = `BLOCK_INSTR_WIDTH,
  parameter int n_instrs    = 64,
  parameter int pc_width    = $clog2(n_instrs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [pc_width-1:0]    cfg_addr,
  input  logic [instr_width-1:0] cfg_data,
  input  logic [pc_width:0]      cfg_len,
  input  logic                   sample_tick,
  output logic [instr_width-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [pc_width-1:0]    pc_out,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   cfg_reject
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [pc_width:0]   max_len = (pc_width+1)'(n_instrs);
  localparam logic [pc_width:0]   one_len = (pc_width+1)'(1);
  localparam logic [pc_width-1:0] one_pc  = pc_width'(1);

  state_t                 state;
  logic [pc_width:0]      len_q;
  logic [pc_width:0]      len_clamped;
  logic [pc_width-1:0]    pc;
  logic [pc_width-1:0]    rd_addr;
  logic [instr_width-1:0] rd_data;
  logic                   last;

  logic [instr_width-1:0] mem [n_instrs];

  assign len_clamped = (cfg_len > max_len) ? max_len : cfg_len;
  // len_q is never 0 in ISSUE, so len_q-1 cannot underflow there
  assign last        = ({1'b0, pc} == (len_q - one_len));

  // Prefetch the next word on a handshake so back-to-back issue needs no
  // bubble; on a stall re-read pc so the presented word stays put.
  always_comb begin
    rd_addr = pc;
    case (state)
      IDLE:    rd_addr = '0;
      ISSUE:   rd_addr = instr_ready ? (pc + one_pc) : pc;
      default: rd_addr = pc;
    endcase
  end

  // Program RAM: no reset so contents survive a control reset
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) mem[cfg_addr] <= cfg_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      len_q       <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      cfg_reject  <= 1'b0;
    end else begin
      cfg_reject <= cfg_we && busy;
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (sample_tick) begin
            len_q <= len_clamped;
            pc    <= '0;
            busy  <= 1'b1;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          state       <= ISSUE;
          instr_valid <= 1'b1;
        end
        ISSUE: begin
          if (instr_ready) begin
            if (last) begin
              state       <= DONE;
              instr_valid <= 1'b0;
              done        <= 1'b1;
            end else begin
              pc <= pc + one_pc;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_out = instr_valid ? rd_data : '0;
  assign pc_out    = pc;

endmodule

// File: doc/block_sequencer.md
Name: block_sequencer

Overview:
- Per-sample instruction sequencer for one processing block.
- Holds the block's program in a local synchronous RAM, loaded over a config write port.
- On each sample tick, issues instructions 0..len-1 in order to the instruction decoder/datapath over a valid/ready handshake, at up to one instruction per cycle.
- Reports busy, done and sample-overrun status to the top-level scheduler.

Parameters:
- instr_width, 32, instruction word width; must equal `BLOCK_INSTR_WIDTH.
- n_instrs, 64, program RAM depth; power of two.
- pc_width, 6, log2(n_instrs).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  program RAM write strobe.
- cfg_addr  input  pc_width  program RAM write address.
- cfg_data  input  instr_width  program RAM write data.
- cfg_len  input  pc_width+1  program length in instructions (0..n_instrs); sampled at tick acceptance.
- sample_tick  input  1  one-cycle pulse that starts one program pass.
- instr_out  output  instr_width  instruction to the decoder.
- instr_valid  output  1  instr_out is valid.
- instr_ready  input  1  downstream accepts instr_out this cycle.
- pc_out  output  pc_width  index of instr_out.
- busy  output  1  a pass is in progress.
- done  output  1  one-cycle pulse at the end of a pass.
- overrun  output  1  sticky flag: a tick was dropped.
- cfg_reject  output  1  one-cycle pulse: a write was ignored because busy was high.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: instr_valid=0, busy=0, done=0, overrun=0, cfg_reject=0, pc_out=0, instr_out=0, state=IDLE, len_q=0.
  - Reset clears control state only; RAM contents are retained.
  - Reset asserted mid-pass aborts the pass immediately. No done pulse.
- Program RAM: single write port and single read port, registered read data (1-cycle latency).
  - Write occurs when cfg_we && !busy.
  - If cfg_we && busy, the write is dropped and cfg_reject pulses the next cycle.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - busy=0.
  - On sample_tick: len_q<=cfg_len, pc<=0.
    - If cfg_len==0 go to DONE, else go to FETCH with read address 0.
- FETCH:
  - busy=1, instr_valid=0.
  - Unconditionally go to ISSUE next cycle; RAM data for pc is then present.
- ISSUE:
  - busy=1, instr_valid=1, instr_out=RAM data, pc_out=pc.
  - Read address = (instr_ready ? pc+1 : pc), so the word after a handshake is ready on the next cycle. Sustained throughput is 1 instruction/cycle.
  - On instr_valid && instr_ready:
    - If pc==len_q-1 go to DONE.
    - Else pc<=pc+1 and stay in ISSUE.
  - While instr_ready=0: instr_out and pc_out are held stable.
- DONE:
  - busy=1, done=1 for exactly one cycle, then go to IDLE.
- Output gating: instr_out reads 0 whenever instr_valid=0.
- Ticks outside IDLE: a sample_tick in FETCH, ISSUE or DONE is dropped and sets overrun=1. overrun is cleared only by reset. A tick arriving on the same cycle the sequencer enters IDLE (i.e. while still in DONE) counts as overrun.
- Latency:
  - tick at cycle T → first instr_valid at T+2.
  - Pass with len=L and ready always high: done at T+2+L, busy low at T+3+L.
- Boundaries:
  - len=n_instrs runs pc 0..n_instrs-1 with no wrap.
  - cfg_len changes mid-pass have no effect, because len_q is latched.
  - cfg_len values > n_instrs are clamped to n_instrs at latch.

Test Plan:
- Load words 0x100+i at addresses 0..4, cfg_len=5, tick with instr_ready=1 → instr_valid for 5 consecutive cycles starting at tick+2, pc_out 0..4, instr_out 0x100..0x104, done pulses at tick+7, busy low at tick+8.
- Same program, instr_ready low on alternating cycles → each instruction held until accepted, no duplicates or skips, pc_out sequence 0,0,1,1,…,4,4, single done pulse.
- cfg_len=0, tick → no instr_valid, done pulses at tick+1, busy 1 for exactly one cycle.
- Second tick during ISSUE of pc=2 → overrun=1 and stays 1, the current pass completes normally, no second pass starts; the next tick in IDLE starts a pass with overrun still 1.
- cfg_we to address 3 with data 0xDEAD while busy → cfg_reject pulses, the next pass still issues the original word at pc 3; the same write in IDLE → pc 3 issues 0xDEAD.
- Assert reset at pc=2 with instr_valid=1 → next cycle all outputs at reset values, no done; a later tick replays the full program from pc 0 with RAM intact.
